// File: rtl/ram_pkg.sv
// Shared constants and FSM encoding for the single-line read buffer.
package ram_pkg;

  localparam int unsigned LINE_BYTES = 8;
  localparam int unsigned BEATS      = 4;
  localparam int unsigned BEAT_W     = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StFill = 2'd2
  } state_e;

endpackage

// File: rtl/ram_line_store.sv
// 8x8 byte register file: 2-byte beat write port, 1-byte snoop write port, async read.
module ram_line_store
  import ram_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              beat_we,
  input  logic [1:0]        beat_idx,
  input  logic [BEAT_W-1:0] beat_data,
  input  logic              snoop_we,
  input  logic [2:0]        snoop_idx,
  input  logic [7:0]        snoop_data,
  input  logic [2:0]        rd_idx,
  output logic [7:0]        rd_data
);

  logic [7:0] line_q [LINE_BYTES];

  // Byte array update; snoop is applied last so it wins on an overlapping byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LINE_BYTES; i++) line_q[i] <= 8'h00;
    end else begin
      if (beat_we) begin
        line_q[{beat_idx, 1'b0}] <= beat_data[7:0];
        line_q[{beat_idx, 1'b1}] <= beat_data[15:8];
      end
      if (snoop_we) line_q[snoop_idx] <= snoop_data;
    end
  end

  assign rd_data = line_q[rd_idx];

endmodule

// File: rtl/ram_line_buffer.sv
// One-line read buffer: zero-latency hits, 4-beat burst refill on miss, write snoop.
module ram_line_buffer #(
  parameter int unsigned ADDR_W = 21,
  parameter int unsigned BEAT_W = 16,
  parameter int unsigned BEATS  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  output logic [7:0]        data,
  output logic              ready,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic              mem_req,
  output logic [ADDR_W-4:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [BEAT_W-1:0] mem_rdata
);

  import ram_pkg::*;

  localparam int unsigned TagW = ADDR_W - 3;

  state_e          state_q, state_d;
  logic [TagW-1:0] tag_q, tag_d;
  logic [TagW-1:0] fill_tag_q, fill_tag_d;
  logic            valid_q, valid_d;
  logic            stale_q, stale_d;
  logic [1:0]      cnt_q, cnt_d;

  logic [TagW-1:0] addr_tag, wr_tag;
  logic            hit, snoop_fill, beat_we, snoop_we;

  assign addr_tag   = addr[ADDR_W-1:3];
  assign wr_tag     = wr_addr[ADDR_W-1:3];
  assign hit        = valid_q && (tag_q == addr_tag) && (state_q == StIdle);
  assign snoop_fill = wr_en && (wr_tag == fill_tag_q);

  assign ready    = hit;
  assign mem_addr = (state_q == StReq) ? fill_tag_q : '0;

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      tag_q      <= '0;
      fill_tag_q <= '0;
      valid_q    <= 1'b0;
      stale_q    <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      fill_tag_q <= fill_tag_d;
      valid_q    <= valid_d;
      stale_q    <= stale_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state, burst handshake and snoop decisions.
  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    fill_tag_d = fill_tag_q;
    valid_d    = valid_q;
    stale_d    = stale_q;
    cnt_d      = cnt_q;
    mem_req    = 1'b0;
    beat_we    = 1'b0;
    snoop_we   = 1'b0;
    case (state_q)
      StIdle: begin
        snoop_we = wr_en && valid_q && (wr_tag == tag_q);
        if (!hit) begin
          fill_tag_d = addr_tag;
          valid_d    = 1'b0;
          stale_d    = 1'b0;
          state_d    = StReq;
        end
      end
      StReq: begin
        mem_req = 1'b1;
        if (snoop_fill) stale_d = 1'b1;
        if (mem_ack) begin
          cnt_d   = 2'd0;
          state_d = StFill;
        end
      end
      StFill: begin
        if (snoop_fill) stale_d = 1'b1;
        if (mem_rvalid) begin
          beat_we = 1'b1;
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'(BEATS - 1)) begin
            tag_d   = fill_tag_q;
            // A write landing on the final beat must still invalidate the line.
            valid_d = !(stale_q || snoop_fill);
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  ram_line_store u_store (
    .clk        (clk),
    .reset      (reset),
    .beat_we    (beat_we),
    .beat_idx   (cnt_q),
    .beat_data  (mem_rdata),
    .snoop_we   (snoop_we),
    .snoop_idx  (wr_addr[2:0]),
    .snoop_data (wr_data),
    .rd_idx     (addr[2:0]),
    .rd_data    (data)
  );

endmodule

// File: tb/tb_ram_line_buffer.sv
// Directed bench for ram_line_buffer with hand-computed expectations.
module tb_ram_line_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [20:0] addr;
  logic [7:0]  data;
  logic        ready;
  logic        wr_en;
  logic [20:0] wr_addr;
  logic [7:0]  wr_data;
  logic        mem_req;
  logic [17:0] mem_addr;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ram_line_buffer #(.ADDR_W(21), .BEAT_W(16), .BEATS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .data       (data),
    .ready      (ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Serve one burst. mode 1: snoop the fill line between beats 2 and 3.
  // mode 2: move addr to 0x00100 during the fill.
  task automatic do_fill(input logic [17:0] exp_tag, input logic [63:0] bytes, input int mode);
    int waited = 0;
    while (!mem_req && waited < 20) begin
      step();
      waited++;
    end
    check("req_seen", {31'd0, mem_req}, 32'd1);
    if (!mem_req) return;
    check("req_addr", {14'd0, mem_addr}, {14'd0, exp_tag});
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    #1;
    check("req_drop", {31'd0, mem_req}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      if (mode == 1 && k == 2) begin
        wr_en   = 1'b1;
        wr_addr = {exp_tag, 3'd5};
        wr_data = 8'hEE;
        step();
        wr_en = 1'b0;
      end
      if (mode == 2 && k == 1) addr = 21'h00100;
      mem_rvalid = 1'b1;
      mem_rdata  = bytes[16*k +: 16];
      step();
      mem_rvalid = 1'b0;
    end
    #1;
  endtask

  initial begin
    logic [63:0] line0;
    logic [7:0]  exp_b;
    line0      = 64'h7766_5544_3322_1100;
    reset      = 1'b1;
    addr       = 21'h00010;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    step();
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_maddr", {14'd0, mem_addr}, 32'd0);
    check("rst_data", {24'd0, data}, 32'd0);

    // First miss with exact cycle accounting: ack in cycle 1, back-to-back beats.
    reset = 1'b0;
    #1;
    check("c0_ready", {31'd0, ready}, 32'd0);
    check("c0_req", {31'd0, mem_req}, 32'd0);
    step();
    check("c1_req", {31'd0, mem_req}, 32'd1);
    check("c1_maddr", {14'd0, mem_addr}, 32'h2);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = line0[16*k +: 16];
      #1;
      check("fill_no_req", {31'd0, mem_req}, 32'd0);
      check("fill_not_ready", {31'd0, ready}, 32'd0);
      step();
    end
    mem_rvalid = 1'b0;
    #1;
    check("c6_ready", {31'd0, ready}, 32'd1);
    check("c6_data", {24'd0, data}, 32'h00);
    addr = 21'h00017;
    #1;
    check("c6_data17", {24'd0, data}, 32'h77);

    // Hit sweep over the whole line.
    for (int i = 0; i < 8; i++) begin
      addr  = 21'h00010 + 21'(i);
      exp_b = 8'(i * 8'h11);
      #1;
      check("sweep_ready", {31'd0, ready}, 32'd1);
      check("sweep_data", {24'd0, data}, {24'd0, exp_b});
      check("sweep_req", {31'd0, mem_req}, 32'd0);
      step();
    end

    // Snoop hit in IDLE.
    addr    = 21'h00013;
    wr_en   = 1'b1;
    wr_addr = 21'h00013;
    wr_data = 8'hAB;
    #1;
    check("snoop_pre", {24'd0, data}, 32'h33);
    step();
    wr_en = 1'b0;
    #1;
    check("snoop_data", {24'd0, data}, 32'hAB);
    check("snoop_ready", {31'd0, ready}, 32'd1);

    // Non-matching write leaves the line alone.
    wr_en   = 1'b1;
    wr_addr = 21'h00113;
    wr_data = 8'h55;
    step();
    wr_en = 1'b0;
    #1;
    check("nomatch_data", {24'd0, data}, 32'hAB);
    check("nomatch_ready", {31'd0, ready}, 32'd1);

    // Snoop into the line being filled forces a refetch.
    addr = 21'h00040;
    #1;
    check("miss40_ready", {31'd0, ready}, 32'd0);
    do_fill(18'h8, 64'hFEDC_BA98_7654_3210, 1);
    check("stale_ready", {31'd0, ready}, 32'd0);
    step();
    check("refetch_req", {31'd0, mem_req}, 32'd1);
    check("refetch_addr", {14'd0, mem_addr}, 32'h8);
    do_fill(18'h8, 64'h8877_6655_4433_2211, 0);
    addr = 21'h00045;
    #1;
    check("refill_ready", {31'd0, ready}, 32'd1);
    check("refill_data", {24'd0, data}, 32'h66);

    // Address change mid-fill: old burst completes, then the new line is requested.
    addr = 21'h00080;
    #1;
    do_fill(18'h10, 64'h0102_0304_0506_0708, 2);
    check("chg_ready", {31'd0, ready}, 32'd0);
    step();
    check("chg_req", {31'd0, mem_req}, 32'd1);
    check("chg_addr", {14'd0, mem_addr}, 32'h20);
    do_fill(18'h20, 64'h1020_3040_5060_70C5, 0);
    check("chg_hit", {31'd0, ready}, 32'd1);
    check("chg_data", {24'd0, data}, 32'hC5);

    // Reset in the middle of a fill.
    addr = 21'h00200;
    step();
    check("rb_req", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1;
    step();
    mem_ack    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 16'hAAAA;
    step();
    mem_rdata = 16'hBBBB;
    step();
    mem_rvalid = 1'b0;
    reset      = 1'b1;
    #1;
    check("rb_req0", {31'd0, mem_req}, 32'd0);
    check("rb_ready0", {31'd0, ready}, 32'd0);
    check("rb_data0", {24'd0, data}, 32'h00);
    step();
    reset      = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 16'hFFFF;
    step();
    step();
    mem_rvalid = 1'b0;
    #1;
    check("rb_rereq", {31'd0, mem_req}, 32'd1);
    check("rb_readdr", {14'd0, mem_addr}, 32'h40);
    for (int i = 0; i < 8; i++) begin
      addr = 21'h00200 + 21'(i);
      #1;
      check("rb_line", {24'd0, data}, 32'h00);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_line_buffer.md
# ram_line_buffer

Single-line (8-byte) read buffer for one read-ahead bank. Two instances sit directly downstream of the read-ahead splitter, one per half-line bank: each receives that bank's byte address, returns the addressed byte and a ready flag, and on a miss fetches the aligned 8-byte line from the memory controller as a 4-beat, 16-bit burst. A write snoop keeps the buffered line coherent with CPU writes.

## Interface
Parameters:
- ADDR_W, 21, byte address width
- BEAT_W, 16, memory read beat width; fixed at 16, only value supported
- BEATS, 4, beats per line (LINE_BYTES = 8)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- addr  in  ADDR_W  requested byte address
- data  out  8  byte addr[2:0] of buffered line (combinational)
- ready  out  1  buffered line valid and matches addr[20:3] (combinational)
- wr_en  in  1  CPU write strobe, one cycle per byte
- wr_addr  in  ADDR_W  CPU write byte address
- wr_data  in  8  CPU write byte
- mem_req  out  1  burst read request, held until mem_ack
- mem_addr  out  ADDR_W-3  line address of burst (addr[20:3])
- mem_ack  in  1  controller accepts request (single-cycle)
- mem_rvalid  in  1  read beat valid
- mem_rdata  in  BEAT_W  read beat

## Operation
- State: line[0..7] bytes, tag[17:0], valid, stale, fill_tag[17:0], beat counter [1:0], FSM {IDLE, REQ, FILL}.
- hit = valid & (tag == addr[20:3]) & (state == IDLE); ready = hit; data = line[addr[2:0]] regardless of hit.
- IDLE: if !hit, capture fill_tag <= addr[20:3], clear valid and stale, go REQ.
- REQ: mem_req = 1, mem_addr = fill_tag; on mem_ack go FILL, beat counter = 0. mem_rvalid in REQ ignored.
- FILL: each mem_rvalid writes line[2k] <= mem_rdata[7:0], line[2k+1] <= mem_rdata[15:8], k = counter, counter increments (wraps 3->0). On 4th beat: tag <= fill_tag, valid <= !stale, go IDLE.
- addr changes during REQ/FILL do not abort the burst; evaluated again in IDLE.
- Snoop: wr_en with wr_addr[20:3] == tag and valid in IDLE -> line[wr_addr[2:0]] <= wr_data same edge. wr_en matching fill_tag in REQ/FILL -> stale <= 1 (line refetched after fill). wr_en and a fill beat in the same cycle: stale wins.
- Non-matching writes ignored.

## Timing
- Reset: state IDLE, valid 0, stale 0, tag 0, fill_tag 0, line all 0x00, counter 0; outputs mem_req 0, mem_addr 0, ready 0, data 0x00.
- Hit: ready and data valid same cycle as addr (zero latency).
- Miss: addr at cycle 0 -> mem_req high cycle 1 -> stays high through mem_ack cycle A -> beats from A+1 onward -> ready high the cycle after the 4th beat edge.
- Minimum miss latency with ack in cycle 1 and back-to-back beats: ready in cycle 6.
- mem_req drops the cycle after mem_ack; never re-asserted before FILL completes.
- reset mid-burst: immediate return to reset state; outstanding beats after reset release ignored (arrive in IDLE).

## Structure
- Shared package/include ram_pkg: LINE_BYTES, BEATS, BEAT_W, state encoding (IDLE=2'd0, REQ=2'd1, FILL=2'd2).
- One sub-module: ram_line_store (8x8 register file, two write ports: beat write of 2 bytes, snoop byte write; one async read port; reset clears).
- FSM, tag/valid/stale, snoop compare in ram_line_buffer.

## Test plan
- Reset then addr=0x00010 -> ready 0, mem_req 1 cycle 1 with mem_addr=0x00002; beats 0x1100,0x3322,0x5544,0x7766 -> ready 1, data=0x00 at addr 0x00010, 0x77 at 0x00017.
- Hit after fill: sweep addr 0x00010..0x00017 -> ready 1 every cycle, data 0x00..0x77, no mem_req.
- Snoop hit: wr_en wr_addr=0x00013 wr_data=0xAB in IDLE -> next cycle data at 0x00013 = 0xAB, ready stays 1.
- Snoop during fill: write to fill line between beats 2 and 3 -> after 4th beat ready stays 0, new mem_req issued for same line.
- Addr change during FILL to 0x00100 -> burst completes for old line, then mem_req with mem_addr=0x00020.
- Reset asserted during FILL after 2 beats -> mem_req 0, ready 0, line all 0x00; stray beats ignored.
